// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit. It follows the destination
// registers of the EX and MEM instructions and registers the bypass selects for the ID consumer.
module fwd_hazard_unit #(
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wr,
  input  logic [RW-1:0] id_rd,
  input  logic          id_load,
  input  logic          flush,
  output logic          stall,
  output logic          fwdA,
  output logic          fwdB,
  output logic          fwdA_src,
  output logic          fwdB_src,
  output logic [CW-1:0] stall_cnt
);

  logic          exValid_q, exWr_q, exLoad_q;
  logic [RW-1:0] exRd_q;
  logic          memValid_q, memWr_q;
  logic [RW-1:0] memRd_q;
  logic          fwdA_q, fwdB_q, fwdASrc_q, fwdBSrc_q;
  logic [CW-1:0] stallCnt_q;

  logic          exValid_d, exWr_d, exLoad_d;
  logic [RW-1:0] exRd_d;
  logic          fwdA_d, fwdB_d, fwdASrc_d, fwdBSrc_d;
  logic [CW-1:0] stallCnt_d;

  logic exHitRs, exHitRt, memHitRs, memHitRt, bubble;

  // Register 0 is hardwired to zero, so a hit on index 0 is always suppressed.
  always_comb begin
    exHitRs  = exValid_q  & exWr_q  & (exRd_q  == id_rs) & (id_rs != '0);
    exHitRt  = exValid_q  & exWr_q  & (exRd_q  == id_rt) & (id_rt != '0);
    memHitRs = memValid_q & memWr_q & (memRd_q == id_rs) & (id_rs != '0);
    memHitRt = memValid_q & memWr_q & (memRd_q == id_rt) & (id_rt != '0);

    stall  = id_valid & ~flush & exLoad_q &
             ((id_use_rs & exHitRs) | (id_use_rt & exHitRt));
    bubble = flush | stall | ~id_valid;

    exValid_d = ~bubble;
    exWr_d    = id_wr;
    exRd_d    = id_rd;
    exLoad_d  = id_load;

    fwdA_d    = 1'b0;
    fwdASrc_d = 1'b0;
    fwdB_d    = 1'b0;
    fwdBSrc_d = 1'b0;
    // The EX producer is newer than the MEM producer, so it wins.
    if (!bubble) begin
      if (id_use_rs && exHitRs) begin
        fwdA_d = 1'b1;
      end else if (id_use_rs && memHitRs) begin
        fwdA_d    = 1'b1;
        fwdASrc_d = 1'b1;
      end
      if (id_use_rt && exHitRt) begin
        fwdB_d = 1'b1;
      end else if (id_use_rt && memHitRt) begin
        fwdB_d    = 1'b1;
        fwdBSrc_d = 1'b1;
      end
    end

    stallCnt_d = stallCnt_q;
    if (stall && (stallCnt_q != {CW{1'b1}})) begin
      stallCnt_d = stallCnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid_q  <= 1'b0;
      exWr_q     <= 1'b0;
      exLoad_q   <= 1'b0;
      exRd_q     <= '0;
      memValid_q <= 1'b0;
      memWr_q    <= 1'b0;
      memRd_q    <= '0;
      fwdA_q     <= 1'b0;
      fwdB_q     <= 1'b0;
      fwdASrc_q  <= 1'b0;
      fwdBSrc_q  <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      memValid_q <= exValid_q;
      memWr_q    <= exWr_q;
      memRd_q    <= exRd_q;
      exValid_q  <= exValid_d;
      exWr_q     <= exWr_d;
      exLoad_q   <= exLoad_d;
      exRd_q     <= exRd_d;
      fwdA_q     <= fwdA_d;
      fwdB_q     <= fwdB_d;
      fwdASrc_q  <= fwdASrc_d;
      fwdBSrc_q  <= fwdBSrc_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign fwdA      = fwdA_q;
  assign fwdB      = fwdB_q;
  assign fwdA_src  = fwdASrc_q;
  assign fwdB_src  = fwdBSrc_q;
  assign stall_cnt = stallCnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Generates the `fwdA`/`fwdB` forwarding controls consumed by the ALU control decoder, plus a load-use stall.
- Tracks destination-register state of the instructions in EX and MEM and compares it against the source registers of the instruction in ID.
- Forwarding decisions are registered, so they are valid exactly during the cycle the consumer sits in EX.
- Sits between the decode stage and the EX-stage operand muxes of the pipelined core.

Parameters:
- RW, 4, register-index width (16 architectural registers).
- CW, 16, width of the saturating stall-event counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RW  source A register index.
- id_rt  in  RW  source B register index.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wr  in  1  instruction writes a register.
- id_rd  in  RW  destination register index.
- id_load  in  1  instruction is a load (result available only at end of MEM).
- flush  in  1  branch redirect; squash the ID instruction.
- stall  out  1  combinational; hold PC/IF/ID, insert bubble into EX.
- fwdA  out  1  registered; EX operand A taken from the bypass network.
- fwdB  out  1  registered; EX operand B taken from the bypass network.
- fwdA_src  out  1  registered; 0 = EX/MEM result, 1 = MEM/WB result.
- fwdB_src  out  1  registered; same encoding as fwdA_src, for operand B.
- stall_cnt  out  CW  registered saturating count of stall cycles.

Behaviour:
- Internal tracking registers:
  - ex_v, ex_wr, ex_rd, ex_ld: the instruction currently in EX.
  - mem_v, mem_wr, mem_rd: the instruction currently in MEM.
- Reset (async on rst_n low): all tracking valids 0; fwdA, fwdB, fwdA_src, fwdB_src = 0; stall_cnt = 0. stall then evaluates to 0.
- Register 0 is hardwired zero and is never a hazard. Any comparison with index 0 yields no match.
- matchEX(r) = ex_v & ex_wr & (ex_rd == r) & (r != 0).
- matchMEM(r) = mem_v & mem_wr & (mem_rd == r) & (r != 0).
- stall = id_valid & ~flush & ex_ld & ((id_use_rs & matchEX(id_rs)) | (id_use_rt & matchEX(id_rt))).
- Every rising edge, in priority order:
  1. MEM always advances: mem_* <= ex_*.
  2. EX loads a bubble (ex_v = 0) if flush | stall | ~id_valid. Otherwise ex_v = 1, ex_wr = id_wr, ex_rd = id_rd, ex_ld = id_load.
  3. Forward outputs follow the same condition:
     - If flush | stall | ~id_valid: all forward outputs <= 0.
     - Else, operand A: if id_use_rs & matchEX(id_rs), then fwdA = 1, fwdA_src = 0.
     - Else if id_use_rs & matchMEM(id_rs), then fwdA = 1, fwdA_src = 1.
     - Else fwdA = 0, fwdA_src = 0.
     - Operand B uses identical rules with id_rt / id_use_rt.
  4. stall_cnt increments when stall = 1, saturating at 2^CW-1.
- The EX match has priority over the MEM match (newest producer wins).
- Latency: forwarding decisions are computed in ID and appear on the outputs one cycle later, while the consumer is in EX.
- Load-use handling:
  - Exactly one stall cycle per load-use pair. After the bubble the load is in MEM, so the held ID instruction forwards with src = 1.
  - Stall never persists more than one cycle for a single load, because ex_v clears on the bubble.
- Flush has priority over stall: with flush = 1, stall = 0 and the ID instruction is squashed. Already-tracked EX/MEM entries still advance and forward normally to later consumers.
- Non-writing instructions (id_wr = 0) occupy a tracking slot but never match.
- Reset mid-stream discards all tracking state; the first instruction after reset never forwards.

Test Plan:
- Back-to-back ALU dependence: I0 writes r3; next cycle I1 reads rs = r3 → one cycle later fwdA = 1, fwdA_src = 0; stall stays 0.
- Distance-2 dependence with priority: I0 writes r5, I1 writes r5, I2 reads rt = r5 → fwdB = 1, fwdB_src = 0 (I1 wins). Remove I1's write → fwdB_src = 1.
- Load-use: load writes r7, next instruction reads rs = r7 → stall = 1 for exactly one cycle, stall_cnt = 1. Next edge: fwdA = 1, fwdA_src = 1.
- Register 0 and unused sources: producer writes r0 while consumer reads r0; separately, a consumer matches r4 on rt with id_use_rt = 0 → fwdA = fwdB = 0 and stall = 0 in both cases.
- Flush versus stall: load r2, then consumer of r2 presented with flush = 1 → stall = 0, forward outputs 0, EX gets a bubble. A following consumer of r2 forwards with src = 1.
- Async reset: assert rst_n low mid-sequence, between clock edges → outputs clear immediately. After release, a reader of a register written before reset gets fwdA = 0. Separately, preset stall_cnt to 0xFFFF and stall once → count stays 0xFFFF.
